// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Purpose  : Round-robin arbiter granting one of NUM_CORES cores access to a
//            single-ported shared memory. Writes take two cycles
//            (ACCESS, IDLE). Reads take three cycles (ACCESS, RDWAIT, IDLE).
//            Read data is returned in RDWAIT.
// Options  : MEM_ARB_BURST_EN - when defined, a core holding lock may keep
//            the memory for up to MAX_BURST consecutive accesses.
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
  parameter int NUM_CORES = 16,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  input  logic [NUM_CORES-1:0]        lock,
  output logic [NUM_CORES-1:0]        grant,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  localparam logic [PTR_W:0]       C_NUM = (PTR_W+1)'(NUM_CORES);
  localparam logic [NUM_CORES-1:0] C_ONE = NUM_CORES'(1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_win;
  logic [PTR_W-1:0]     w_sel;
  logic [PTR_W-1:0]     w_load_idx;
  logic [PTR_W-1:0]     w_ptr_inc;
  logic [PTR_W:0]       w_scan;
  logic                 w_found;
  logic                 w_any;
  logic                 w_cont;
  logic                 w_rd_cont;

  logic [NUM_CORES-1:0] r_grant;
  logic [NUM_CORES-1:0] r_rvalid;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;

  logic [NUM_CORES-1:0] w_grant_nxt;
  logic [NUM_CORES-1:0] w_rvalid_nxt;
  logic                 w_mem_en_nxt;
  logic                 w_mem_we_nxt;
  logic [ADDR_W-1:0]    w_mem_addr_nxt;
  logic [DATA_W-1:0]    w_mem_wdata_nxt;

  assign w_any = |req;

  // Winner: first requesting core at or above the pointer, scanning upward
  // with wrap-around. The scan index never exceeds 2*NUM_CORES-2, so a
  // single conditional subtraction is enough to wrap it.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_scan  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_scan >= C_NUM) begin
        w_scan = w_scan - C_NUM;
      end
      if (!w_found && req[w_scan[PTR_W-1:0]]) begin
        w_sel   = w_scan[PTR_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  // Pointer moves to the core just after the last winner.
  assign w_ptr_inc = ({1'b0, r_win} == (C_NUM - 1'b1)) ? '0 : (r_win + 1'b1);

`ifdef MEM_ARB_BURST_EN
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] C_BURST_LAST = BURST_W'(MAX_BURST - 1);

  logic [BURST_W-1:0] r_burst;
  logic               r_cont;

  // Burst continues only while the owner still requests and holds lock.
  assign w_cont = (r_state == ST_ACCESS) && lock[r_win] && req[r_win] &&
                  (r_burst < C_BURST_LAST);

  assign w_rd_cont = r_cont;

  // Burst counter and read-continuation flag, decided once per ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_burst <= '0;
      r_cont  <= 1'b0;
    end else if (r_state == ST_ACCESS) begin
      if (w_cont) begin
        r_burst <= r_burst + 1'b1;
        r_cont  <= 1'b1;
      end else begin
        r_burst <= '0;
        r_cont  <= 1'b0;
      end
    end
  end
`else
  logic w_unused_lock;

  assign w_cont        = 1'b0;
  assign w_rd_cont     = 1'b0;
  assign w_unused_lock = ^lock;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_mem_we) begin
          w_state_next = w_cont ? ST_ACCESS : ST_IDLE;
        end else begin
          w_state_next = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        w_state_next = w_rd_cont ? ST_ACCESS : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Core whose request fields are captured on entry to ACCESS: a fresh
  // winner from IDLE, otherwise the current burst owner.
  assign w_load_idx = (r_state == ST_IDLE) ? w_sel : r_win;

  // Output logic: next values of the registered outputs, derived from the
  // state being entered so that all outputs appear in the same cycle.
  always_comb begin
    w_grant_nxt     = '0;
    w_rvalid_nxt    = '0;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    if (w_state_next == ST_ACCESS) begin
      w_grant_nxt     = C_ONE << w_load_idx;
      w_mem_en_nxt    = 1'b1;
      w_mem_we_nxt    = we[w_load_idx];
      w_mem_addr_nxt  = addr[w_load_idx*ADDR_W +: ADDR_W];
      w_mem_wdata_nxt = wdata[w_load_idx*DATA_W +: DATA_W];
    end
    if (w_state_next == ST_RDWAIT) begin
      w_rvalid_nxt = C_ONE << r_win;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant     <= '0;
      r_rvalid    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Winner capture in IDLE and pointer advance when a transaction ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= '0;
      r_ptr <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_win <= w_sel;
      end
      if ((r_state != ST_IDLE) && (w_state_next == ST_IDLE)) begin
        r_ptr <= w_ptr_inc;
      end
    end
  end

  assign grant     = r_grant;
  assign rvalid    = r_rvalid;
  assign rdata     = mem_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_arbiter
// Purpose  : Scoreboard bench for core_mem_arbiter with a behavioural memory.
//            Burst expectations follow MEM_ARB_BURST_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

  localparam int NC = 16;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] req, we, lock;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic [NC-1:0] grant, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  core_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lock(lock), .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Cycle counter: value k during the cycle following the k-th rising edge.
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural memory: unwritten locations return a fixed pattern.
  logic [DW-1:0] mem [256];
  bit            mem_valid [256];

  function automatic logic [DW-1:0] mem_dflt(input logic [AW-1:0] a);
    return (a == 8'h40) ? 8'h5C : (a ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we)
      mem_rdata <= mem_valid[mem_addr] ? mem[mem_addr] : mem_dflt(mem_addr);
    if (mem_en && mem_we) begin
      mem[mem_addr]       <= mem_wdata;
      mem_valid[mem_addr] <= 1'b1;
    end
  end

  typedef struct {
    logic [NC-1:0] g;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } acc_t;

  typedef struct {
    logic [NC-1:0] v;
    logic [DW-1:0] d;
  } rd_t;

  acc_t acc_q[$];
  rd_t  rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_core(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic exp_acc(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int cyc);
    acc_t e;
    e.g = NC'(1) << i;
    e.w = w;
    e.a = a;
    e.d = d;
    e.cyc = cyc;
    acc_q.push_back(e);
  endtask

  task automatic exp_rd(input int i, input logic [DW-1:0] d);
    rd_t e;
    e.v = NC'(1) << i;
    e.d = d;
    rd_q.push_back(e);
  endtask

  // Raise the given requests, dropping each one once its grant is seen.
  task automatic run_req(input logic [NC-1:0] mask, input string name);
    req = mask;
    for (int c = 0; c < 120 && req != 0; c++) begin
      @(posedge clk); #1;
      req = req & ~grant;
    end
    if (req != 0) begin
      chk({name, "_timeout"}, 64'(req), 64'(0));
      req = '0;
    end
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an access or
  // read data, and checks the one-hot/exclusivity invariants every cycle.
  int last_acc_cyc = -10;
  initial begin
    acc_t ea;
    rd_t  er;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("onehot", 64'({$countones(grant) > 1, $countones(rvalid) > 1, mem_en && (rvalid != 0)}), 64'(0));
        chk("grant_without_mem_en", 64'(mem_en ? '0 : grant), 64'(0));
        if (mem_en) begin
          if (acc_q.size() == 0) begin
            chk("unexpected_access", 64'(acc_q.size()), 64'(1));
          end else begin
            ea = acc_q.pop_front();
            chk("access", 64'({grant, mem_we, mem_addr, mem_wdata}), 64'({ea.g, ea.w, ea.a, ea.d}));
            if (ea.cyc >= 0) chk("access_cycle", 64'(cyc_cnt), 64'(ea.cyc));
          end
          last_acc_cyc = cyc_cnt;
        end
        if (rvalid != 0) begin
          if (rd_q.size() == 0) begin
            chk("unexpected_rvalid", 64'(rd_q.size()), 64'(1));
          end else begin
            er = rd_q.pop_front();
            chk("read", 64'({rvalid, rdata}), 64'({er.v, er.d}));
            chk("read_cycle", 64'(cyc_cnt), 64'(last_acc_cyc + 1));
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int n;
    int n2;
    int k2;
    int base;
    int rv_cnt;
    int seq [7];

    reset = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    #3;
    chk("reset_outputs", 64'({grant, rvalid, mem_en, mem_we, mem_addr, mem_wdata}), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_grant", 64'(grant), 64'(0));
      chk("idle_mem_en", 64'(mem_en), 64'(0));
    end

    // Core 3 write, one cycle after sampling.
    set_core(3, 1'b1, 8'h12, 8'hA5);
    exp_acc(3, 1'b1, 8'h12, 8'hA5, cyc_cnt + 1);
    run_req(16'h0008, "core3_write");
    gap();

    // Pointer now 4: core 5 beats core 2, core 2 follows two cycles later.
    set_core(2, 1'b1, 8'h22, 8'h02);
    set_core(5, 1'b1, 8'h25, 8'h05);
    exp_acc(5, 1'b1, 8'h25, 8'h05, cyc_cnt + 1);
    exp_acc(2, 1'b1, 8'h22, 8'h02, cyc_cnt + 3);
    run_req(16'h0024, "ptr_after_core3");
    gap();

    // Core 0 read of 0x40 returns 0x5C.
    set_core(0, 1'b0, 8'h40, 8'h00);
    exp_acc(0, 1'b0, 8'h40, 8'h00, cyc_cnt + 1);
    exp_rd(0, 8'h5C);
    run_req(16'h0001, "core0_read");
    gap();

    // Core 1 reads back the value written by core 3.
    set_core(1, 1'b0, 8'h12, 8'h00);
    exp_acc(1, 1'b0, 8'h12, 8'h00, cyc_cnt + 1);
    exp_rd(1, 8'hA5);
    run_req(16'h0002, "core1_readback");
    gap();

    // Core 15 write moves the pointer back to 0.
    set_core(15, 1'b1, 8'h9F, 8'h11);
    exp_acc(15, 1'b1, 8'h9F, 8'h11, cyc_cnt + 1);
    run_req(16'h8000, "core15_write");
    gap();

    // All cores requesting constantly: 0..15 then 0, two cycles apart.
    for (int i = 0; i < NC; i++) set_core(i, 1'b1, 8'(8'h80 + i), 8'(8'hC0 ^ i));
    base = cyc_cnt;
    for (int j = 0; j < 17; j++) exp_acc(j % NC, 1'b1, 8'(8'h80 + (j % NC)), 8'(8'hC0 ^ (j % NC)), base + 1 + 2 * j);
    req = 16'hFFFF;
    n = 0;
    for (int c = 0; c < 80 && n < 17; c++) begin
      @(posedge clk); #1;
      if (mem_en) n++;
    end
    req = '0;
    chk("all_req_grants_seen", 64'(n), 64'(17));
    gap();

    // Core 2 locked burst of 6 writes against a single core 7 write.
`ifdef MEM_ARB_BURST_EN
    seq = '{2, 2, 2, 2, 7, 2, 2};
`else
    seq = '{2, 7, 2, 2, 2, 2, 2};
`endif
    k2 = 0;
    for (int j = 0; j < 7; j++) begin
      if (seq[j] == 2) begin
        exp_acc(2, 1'b1, 8'(8'h20 + k2), 8'(8'h30 + k2), -1);
        k2++;
      end else begin
        exp_acc(7, 1'b1, 8'h77, 8'h7E, -1);
      end
    end
    set_core(2, 1'b1, 8'h20, 8'h30);
    set_core(7, 1'b1, 8'h77, 8'h7E);
    lock[2] = 1'b1;
    req = 16'h0084;
    n2 = 0;
    for (int c = 0; c < 80 && req != 0; c++) begin
      @(posedge clk); #1;
      if (grant[2]) begin
        n2++;
        if (n2 == 6) begin
          req[2]  = 1'b0;
          lock[2] = 1'b0;
        end else begin
          set_core(2, 1'b1, 8'(8'h20 + n2), 8'(8'h30 + n2));
        end
      end
      if (grant[7]) req[7] = 1'b0;
    end
    req = '0;
    lock = '0;
    chk("burst_core2_grants", 64'(n2), 64'(6));
    gap();

    // Reset asserted during RDWAIT of a core 5 read aborts it.
    set_core(5, 1'b0, 8'h55, 8'h00);
    exp_acc(5, 1'b0, 8'h55, 8'h00, cyc_cnt + 1);
    req = 16'h0020;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (grant[5]) begin
        req = '0;
        break;
      end
    end
    req = '0;
    @(posedge clk); #1;
    chk("rdwait_rvalid", 64'(rvalid), 64'(16'h0020));
    #1 reset = 1'b0;
    #1;
    chk("reset_abort_outputs", 64'({grant, rvalid, mem_en, mem_we, mem_addr, mem_wdata}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid != 0) rv_cnt++;
    end
    chk("no_rvalid_after_reset", 64'(rv_cnt), 64'(0));

    repeat (3) @(posedge clk);
    #1;
    chk("access_queue_drained", 64'(acc_q.size()), 64'(0));
    chk("read_queue_drained", 64'(rd_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
